// File: rtl/tmds_encoder_dvi.sv
// Single-channel DVI TMDS 8b/10b encoder: transition minimisation, then DC balance.
// Optional macro TMDS_PIPELINE_EN adds an input register stage (latency 3 instead of 2).
module tmds_encoder_dvi #(
   parameter int unsigned CNT_W = 5
) (
   input  logic       clk_pix,
   input  logic       rst_pix,
   input  logic [7:0] data_in,
   input  logic [1:0] ctrl_in,
   input  logic       de_in,
   output logic [9:0] tmds_out
);

   localparam logic [9:0] SYM_C00 = 10'h354;
   localparam logic [9:0] SYM_C01 = 10'h0AB;
   localparam logic [9:0] SYM_C10 = 10'h154;
   localparam logic [9:0] SYM_C11 = 10'h2AB;

   logic [7:0] data_p;
   logic [1:0] ctrl_p;
   logic       de_p;

`ifdef TMDS_PIPELINE_EN
   // Input capture; resets to blanking so the output holds the 00 control symbol.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         data_p <= '0;
         ctrl_p <= '0;
         de_p   <= 1'b0;
      end else begin
         data_p <= data_in;
         ctrl_p <= ctrl_in;
         de_p   <= de_in;
      end
   end
`else
   always_comb begin
      data_p = data_in;
      ctrl_p = ctrl_in;
      de_p   = de_in;
   end
`endif

   // Stage 1: choose XOR or XNOR chain to minimise transitions.
   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] q_m_c;

   always_comb begin
      n1d = '0;
      for (int i = 0; i < 8; i++) n1d = n1d + 4'(data_p[i]);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_p[0]);
      q_m_c    = '0;
      q_m_c[0] = data_p[0];
      for (int i = 1; i < 8; i++)
         q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ data_p[i]) : (q_m_c[i-1] ^ data_p[i]);
      q_m_c[8] = ~use_xnor;
   end

   logic [8:0] q_m;
   logic       de_s1;
   logic [1:0] ctrl_s1;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         q_m     <= '0;
         de_s1   <= 1'b0;
         ctrl_s1 <= '0;
      end else begin
         q_m     <= q_m_c;
         de_s1   <= de_p;
         ctrl_s1 <= ctrl_p;
      end
   end

   // Stage 2: invert or pass the data byte to steer the running disparity toward zero.
   logic [3:0]              n1;
   logic signed [CNT_W-1:0] n1_s;
   logic signed [CNT_W-1:0] n0_s;
   logic signed [CNT_W-1:0] qm8_x2;
   logic signed [CNT_W-1:0] nqm8_x2;
   logic signed [CNT_W-1:0] cnt;
   logic signed [CNT_W-1:0] cnt_nxt;
   logic                    cnt_pos;
   logic                    cnt_neg;
   logic [9:0]              tmds_nxt;

   always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + 4'(q_m[i]);
      n1_s     = $signed(CNT_W'(n1));
      n0_s     = $signed(CNT_W'(4'd8 - n1));
      qm8_x2   = q_m[8] ? $signed(CNT_W'(2)) : '0;
      nqm8_x2  = q_m[8] ? '0 : $signed(CNT_W'(2));
      cnt_neg  = cnt[CNT_W-1];
      cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
      tmds_nxt = SYM_C00;
      cnt_nxt  = cnt;
      if (!de_s1) begin
         case (ctrl_s1)
            2'b00:   tmds_nxt = SYM_C00;
            2'b01:   tmds_nxt = SYM_C01;
            2'b10:   tmds_nxt = SYM_C10;
            default: tmds_nxt = SYM_C11;
         endcase
         cnt_nxt = '0;
      end else if ((cnt == '0) || (n1 == 4'd4)) begin
         tmds_nxt = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
         cnt_nxt  = q_m[8] ? (cnt + (n1_s - n0_s)) : (cnt + (n0_s - n1_s));
      end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
         tmds_nxt = {1'b1, q_m[8], ~q_m[7:0]};
         cnt_nxt  = cnt + qm8_x2 + (n0_s - n1_s);
      end else begin
         tmds_nxt = {1'b0, q_m[8], q_m[7:0]};
         cnt_nxt  = cnt + (n1_s - n0_s) - nqm8_x2;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         tmds_out <= SYM_C00;
         cnt      <= '0;
      end else begin
         tmds_out <= tmds_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi: directed DVI cases plus random traffic against a reference model.
module tb_tmds_encoder_dvi;

`ifdef TMDS_PIPELINE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic       clk_pix = 1'b0;
   logic       rst_pix;
   logic [7:0] data_in;
   logic [1:0] ctrl_in;
   logic       de_in;
   logic [9:0] tmds_out;

   tmds_encoder_dvi #(.CNT_W(5)) dut (
      .clk_pix  (clk_pix),
      .rst_pix  (rst_pix),
      .data_in  (data_in),
      .ctrl_in  (ctrl_in),
      .de_in    (de_in),
      .tmds_out (tmds_out)
   );

   always #5 clk_pix = ~clk_pix;

   typedef struct {
      logic [9:0] sym;
      bit         de;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   mcnt    = 0;
   bit   started = 1'b0;

   // Reference: the disparity counter is the running (ones - zeros) of emitted symbols.
   function automatic logic [9:0] model(input bit de, input logic [1:0] c, input logic [7:0] d);
      logic [7:0] qm;
      logic [9:0] sym;
      bit         xnor_path;
      bit         qm8;
      bit         inv;
      int         bal;
      if (!de) begin
         mcnt = 0;
         case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      xnor_path = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = xnor_path ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
      qm8 = !xnor_path;
      bal = 2 * $countones(qm) - 8;
      if (mcnt == 0 || bal == 0) inv = !qm8;
      else                       inv = ((mcnt > 0) == (bal > 0));
      sym  = {inv, qm8, inv ? ~qm : qm};
      mcnt = mcnt + 2 * $countones(sym) - 10;
      return sym;
   endfunction

   task automatic cycle(input bit rst, input bit de, input logic [1:0] c, input logic [7:0] d,
                        input int tag, input bit fixed, input logic [9:0] fx);
      exp_t e;
      logic [9:0] m;
      rst_pix = rst;
      de_in   = de;
      ctrl_in = c;
      data_in = d;
      if (rst) begin
         sb.delete();
         mcnt = 0;
         for (int i = 0; i < LAT; i++) begin
            e.sym = 10'h354; e.de = 1'b0; e.tag = tag;
            sb.push_back(e);
         end
      end else begin
         m     = model(de, c, d);
         e.sym = fixed ? fx : m;
         e.de  = de;
         e.tag = tag;
         sb.push_back(e);
      end
      @(negedge clk_pix);
      #1;
   endtask

   // Monitor: one symbol per clock; also bounds the per-run disparity of data symbols.
   initial begin
      exp_t e;
      int   run;
      run = 0;
      forever begin
         @(negedge clk_pix);
         if (started) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL underflow: no expected symbol queued at t=%0t", $time);
            end else begin
               e = sb.pop_front();
               if (tmds_out !== e.sym) begin
                  errors++;
                  $display("FAIL sym tag=%0d t=%0t got=%h exp=%h", e.tag, $time, tmds_out, e.sym);
               end
               if (e.de) begin
                  run = run + 2 * $countones(tmds_out) - 10;
                  checks++;
                  if (run > 16 || run < -16) begin
                     errors++;
                     $display("FAIL disparity tag=%0d got=%0d exp=|x|<=16", e.tag, run);
                  end
               end else begin
                  run = 0;
               end
            end
         end
      end
   end

   initial begin
      logic [9:0] ctl_sym [4];
      logic [9:0] zero_seq [3];
      bit         de_r;
      ctl_sym[0] = 10'h354; ctl_sym[1] = 10'h0AB; ctl_sym[2] = 10'h154; ctl_sym[3] = 10'h2AB;
      zero_seq[0] = 10'h100; zero_seq[1] = 10'h3FF; zero_seq[2] = 10'h100;
      started = 1'b1;

      // Reset state
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'b00, 8'h00, 0, 1'b0, 10'h0);

      // Blanking control symbols (data ignored)
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b0, 2'(i), 8'($urandom), 1, 1'b1, ctl_sym[i]);

      // All-zero data from cnt=0
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, 2'($urandom), 8'h00, 2, 1'b1, zero_seq[i]);

      // All-ones via XNOR path, then DE falls
      cycle(1'b0, 1'b0, 2'b00, 8'h00, 3, 1'b1, 10'h354);
      cycle(1'b0, 1'b1, 2'b00, 8'hFF, 3, 1'b1, 10'h200);
      cycle(1'b0, 1'b0, 2'b00, 8'hFF, 3, 1'b1, 10'h354);

      // Reset asserted mid-line
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'b00, 8'($urandom), 4, 1'b0, 10'h0);
      cycle(1'b1, 1'b1, 2'b00, 8'($urandom), 4, 1'b0, 10'h0);
      cycle(1'b0, 1'b1, 2'b00, 8'h00, 4, 1'b1, 10'h100);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b00, 8'($urandom), 4, 1'b0, 10'h0);

      // Random traffic with DE runs and rare resets
      de_r = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 19) == 0) de_r = !de_r;
         cycle(($urandom_range(0, 999) == 0), de_r, 2'($urandom), 8'($urandom), 5, 1'b0, 10'h0);
      end

      // Drain with blanking
      for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 1'b0, 2'b00, 8'h00, 6, 1'b0, 10'h0);
      started = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
